dpc_multi: RTL and testbench

Parametrised datapath controller for the multi-channel FIR filter. It generalises the fixed 5-tap sequencer to N_TAPS taps and N_CH time-multiplexed channels, and drives the tap coefficient and channel indices explicitly. It sits between the control interface (ul_in/dl_in), the external sample handshake (extready_in) and the filter datapath, issuing one dp_cmd_t per clock.

---
 rtl/myfilter_pkg.sv | 34 +++
 rtl/dpc_idx_cnt.sv | 31 +++
 rtl/dpc_multi.sv | 139 +++++++++++++
 tb/tb_dpc_multi.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myfilter_pkg.sv
// Shared types and limits for the multi-channel FIR filter datapath controller.
// Holds the datapath command set, the controller state encoding and legal parameter ranges.
package myfilter_pkg;

    localparam int N_TAPS_MIN = 2;
    localparam int N_TAPS_MAX = 64;
    localparam int N_CH_MIN   = 1;
    localparam int N_CH_MAX   = 16;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_SHIFT,
        CMD_MAC_FIRST,
        CMD_MAC,
        CMD_SAT_SH,
        CMD_OUT
    } dp_cmd_t;

    typedef enum logic [2:0] {
        ST_STOPPED,
        ST_PROGRAM,
        ST_EXTIN,
        ST_SHIFT,
        ST_MAC,
        ST_SAT,
        ST_EXTOUT
    } dpcm_fsm_t;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dpc_idx_cnt.sv
// Wrap-around index counter (0..MOD-1) with synchronous clear, enable and terminal count.
// Used for the tap and channel indices of dpc_multi.
module dpc_idx_cnt #(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign tc = (cnt == LAST);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/dpc_multi.sv
// Datapath controller for the N_TAPS-tap, N_CH-channel time-multiplexed FIR filter.
// Optional sticky overrun detection is built when DPC_OVERRUN_EN is defined.
module dpc_multi
    import myfilter_pkg::*;
#(
    parameter int  N_TAPS = 5,
    parameter int  N_CH   = 1,
    localparam int TW     = $clog2(N_TAPS),
    localparam int CW     = idx_width(N_CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ul_in,
    input  logic          dl_in,
    input  logic          extready_in,
    output dp_cmd_t       cmd_out,
    output logic [TW-1:0] tap_idx_out,
    output logic [CW-1:0] ch_idx_out,
    output logic          busy_out
`ifdef DPC_OVERRUN_EN
    ,
    output logic          overrun_out
`endif
);

    dpcm_fsm_t     state_r, state_nxt;
    logic          abort;
    logic          tap_clr, tap_en, tap_tc;
    logic          ch_clr, ch_en, ch_tc;
    logic [TW-1:0] tap_cnt;
    logic [CW-1:0] ch_cnt;

    assign abort = ul_in | dl_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_STOPPED;
        end else begin
            state_r <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state_r;
        cmd_out   = CMD_NOP;
        busy_out  = 1'b0;
        tap_en    = 1'b0;
        tap_clr   = 1'b0;
        ch_en     = 1'b0;
        ch_clr    = 1'b0;
        unique case (state_r)
            ST_STOPPED: begin
                if (ul_in) state_nxt = ST_PROGRAM;
            end
            ST_PROGRAM: begin
                if (dl_in)       state_nxt = ST_STOPPED;
                else if (!ul_in) state_nxt = ST_EXTIN;
            end
            ST_EXTIN: begin
                busy_out = extready_in;
                if (abort) begin
                    state_nxt = ST_STOPPED;
                end else if (extready_in) begin
                    cmd_out   = CMD_SHIFT;
                    state_nxt = ST_MAC;
                end
            end
            ST_SHIFT, ST_MAC, ST_SAT: begin
                busy_out = 1'b1;
                if (abort) begin
                    // Partial results are abandoned; both indices restart from zero.
                    state_nxt = ST_STOPPED;
                    tap_clr   = 1'b1;
                    ch_clr    = 1'b1;
                end else if (state_r == ST_SHIFT) begin
                    cmd_out   = CMD_SHIFT;
                    state_nxt = ST_MAC;
                end else if (state_r == ST_MAC) begin
                    cmd_out   = (tap_cnt == '0) ? CMD_MAC_FIRST : CMD_MAC;
                    tap_en    = 1'b1;
                    if (tap_tc) state_nxt = ST_SAT;
                end else begin
                    cmd_out   = CMD_SAT_SH;
                    state_nxt = ST_EXTOUT;
                end
            end
            ST_EXTOUT: begin
                // Output write-back always completes, even if an abort is requested.
                busy_out  = 1'b1;
                cmd_out   = CMD_OUT;
                ch_en     = 1'b1;
                state_nxt = ch_tc ? ST_PROGRAM : ST_SHIFT;
            end
            default: begin
                state_nxt = ST_STOPPED;
            end
        endcase
    end

    assign tap_idx_out = (cmd_out == CMD_MAC_FIRST || cmd_out == CMD_MAC) ? tap_cnt : '0;
    assign ch_idx_out  = ch_cnt;

    dpc_idx_cnt #(.MOD(N_TAPS), .W(TW)) u_tap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tap_clr),
        .en    (tap_en),
        .cnt   (tap_cnt),
        .tc    (tap_tc)
    );

    dpc_idx_cnt #(.MOD(N_CH), .W(CW)) u_ch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ch_clr),
        .en    (ch_en),
        .cnt   (ch_cnt),
        .tc    (ch_tc)
    );

`ifdef DPC_OVERRUN_EN
    logic overrun_r;

    // A new sample set arriving while one is still in flight latches until re-programming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (state_r == ST_STOPPED && ul_in) begin
            overrun_r <= 1'b0;
        end else if (extready_in && (state_r inside {ST_SHIFT, ST_MAC, ST_SAT, ST_EXTOUT})) begin
            overrun_r <= 1'b1;
        end
    end

    assign overrun_out = overrun_r;
`endif

endmodule

// File: tb/tb_dpc_multi.sv
// Self-checking bench for dpc_multi (N_TAPS=5, N_CH=2) against a sample-set position model.
// Overrun checks are compiled in when DPC_OVERRUN_EN is defined.
module tb_dpc_multi;
    import myfilter_pkg::*;

    localparam int N_TAPS  = 5;
    localparam int N_CH    = 2;
    localparam int P       = N_TAPS + 3;
    localparam int SET_LEN = N_CH * P;
    localparam int TW      = $clog2(N_TAPS);
    localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ul = 1'b0, dl = 1'b0, ext = 1'b0;
    dp_cmd_t       cmd;
    logic [TW-1:0] tap;
    logic [CW-1:0] ch;
    logic          busy;
`ifdef DPC_OVERRUN_EN
    logic          ovr;
`endif

    dpc_multi #(.N_TAPS(N_TAPS), .N_CH(N_CH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ul_in       (ul),
        .dl_in       (dl),
        .extready_in (ext),
        .cmd_out     (cmd),
        .tap_idx_out (tap),
        .ch_idx_out  (ch),
        .busy_out    (busy)
`ifdef DPC_OVERRUN_EN
        ,
        .overrun_out (ovr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        dp_cmd_t       cmd;
        logic [TW-1:0] tap;
        logic [CW-1:0] ch;
        logic          busy;
        logic          ovr;
    } obs_t;

    // Model: idle modes plus a position k inside the current sample set.
    typedef enum {M_STOP, M_PROG, M_WAIT, M_RUN} mode_t;
    mode_t m_mode = M_STOP;
    int    m_k    = 0;
    bit    m_ovr  = 1'b0;
    int    checks = 0;
    int    errors = 0;
    obs_t  rst_exp = '{cmd: CMD_NOP, tap: '0, ch: '0, busy: 1'b0, ovr: 1'b0};

    function automatic obs_t model_out();
        obs_t e;
        int   pos;
        e.cmd  = CMD_NOP;
        e.tap  = '0;
        e.ch   = '0;
        e.busy = 1'b0;
`ifdef DPC_OVERRUN_EN
        e.ovr  = m_ovr;
`else
        e.ovr  = 1'b0;
`endif
        if (m_mode == M_WAIT) begin
            e.busy = ext;
            if (!(ul || dl) && ext) e.cmd = CMD_SHIFT;
        end else if (m_mode == M_RUN) begin
            pos    = m_k % P;
            e.busy = 1'b1;
            e.ch   = CW'(m_k / P);
            if (pos == P - 1) begin
                e.cmd = CMD_OUT;
            end else if (!(ul || dl)) begin
                if (pos == 0) begin
                    e.cmd = CMD_SHIFT;
                end else if (pos <= N_TAPS) begin
                    e.cmd = (pos == 1) ? CMD_MAC_FIRST : CMD_MAC;
                    e.tap = TW'(pos - 1);
                end else begin
                    e.cmd = CMD_SAT_SH;
                end
            end
        end
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o.cmd  = cmd;
        o.tap  = tap;
        o.ch   = ch;
        o.busy = busy;
`ifdef DPC_OVERRUN_EN
        o.ovr  = ovr;
`else
        o.ovr  = 1'b0;
`endif
        return o;
    endfunction

    function automatic string fmt(input obs_t v);
        return $sformatf("cmd=%0d tap=%0d ch=%0d busy=%b ovr=%b", v.cmd, v.tap, v.ch, v.busy, v.ovr);
    endfunction

    task automatic model_step();
        bit ab;
        ab = ul || dl;
        if (m_mode == M_RUN && ext) m_ovr = 1'b1;
        case (m_mode)
            M_STOP: if (ul) begin m_mode = M_PROG; m_ovr = 1'b0; end
            M_PROG: begin
                if (dl)       m_mode = M_STOP;
                else if (!ul) m_mode = M_WAIT;
            end
            M_WAIT: begin
                if (ab)       m_mode = M_STOP;
                else if (ext) begin m_mode = M_RUN; m_k = 1; end
            end
            M_RUN: begin
                if (m_k % P == P - 1) begin
                    if (m_k == SET_LEN - 1) begin m_mode = M_PROG; m_k = 0; end
                    else m_k++;
                end else if (ab) begin
                    m_mode = M_STOP;
                    m_k    = 0;
                end else begin
                    m_k++;
                end
            end
            default: m_mode = M_STOP;
        endcase
    endtask

    task automatic drive(input bit u, input bit d, input bit e);
        ul  = u;
        dl  = d;
        ext = e;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        ul = 1'b0; dl = 1'b0; ext = 1'b0;
        rst_n  = 1'b0;
        m_mode = M_STOP;
        m_k    = 0;
        m_ovr  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic goto_extin();
        apply_reset();
        drive(1, 0, 0);
        tick();
        drive(0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        obs_t o, e;
        #2;
        o = observed();
        checks++;
        if (o !== rst_exp) begin
            errors++;
            $display("FAIL reset_state: got %s, expected %s", fmt(o), fmt(rst_exp));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(c == 1, 0, 0);
            e = model_out();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_startup c%0d: got %s, expected %s", c, fmt(o), fmt(e));
            end
            tick();
        end
    endtask

    task automatic test_sequence();
        obs_t o, e;
        int   shift2 = -1;
        goto_extin();
        for (int c = -3; c < SET_LEN + 6 && shift2 < 0; c++) begin
            drive(0, 0, (c == 0) || (c >= SET_LEN));
            e = model_out();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sequence c%0d: got %s, expected %s", c, fmt(o), fmt(e));
            end
            if (c > 0 && o.cmd === CMD_SHIFT && o.ch === '0) shift2 = c;
            tick();
        end
        checks++;
        if (shift2 != SET_LEN + 1) begin
            errors++;
            $display("FAIL set_period: got %0d, expected %0d", shift2, SET_LEN + 1);
        end
    endtask

    task automatic test_abort_mac();
        obs_t o, e;
        goto_extin();
        for (int c = 0; c < P + 8; c++) begin
            drive(0, c == P + 3, c == 0);
            e = model_out();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_mac c%0d: got %s, expected %s", c, fmt(o), fmt(e));
            end
            if (c == P + 3) begin
                checks++;
                if (o.cmd !== CMD_NOP) begin
                    errors++;
                    $display("FAIL abort_mac_nop: got %0d, expected %0d", o.cmd, CMD_NOP);
                end
            end
            tick();
        end
    endtask

    task automatic test_abort_extout();
        obs_t o, e;
        goto_extin();
        for (int c = 0; c < SET_LEN + 5; c++) begin
            drive(c == P - 1 || c == SET_LEN - 1 || c == SET_LEN, 0, c == 0);
            e = model_out();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_extout c%0d: got %s, expected %s", c, fmt(o), fmt(e));
            end
            tick();
        end
    endtask

    task automatic test_ext_abort_extin();
        obs_t o, e;
        for (int v = 0; v < 2; v++) begin
            goto_extin();
            for (int c = 0; c < 5; c++) begin
                drive(v == 1 && c == 0, v == 0 && c == 0, c < 2);
                e = model_out();
                o = observed();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL ext_abort v%0d c%0d: got %s, expected %s", v, c, fmt(o), fmt(e));
                end
                if (c == 0) begin
                    checks++;
                    if (o.cmd !== CMD_NOP) begin
                        errors++;
                        $display("FAIL ext_abort_nop v%0d: got %0d, expected %0d", v, o.cmd, CMD_NOP);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        goto_extin();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, c == 0);
            tick();
        end
        drive(0, 0, 0);
        rst_n = 1'b0;
        #1;
        o = observed();
        checks++;
        if (o !== rst_exp) begin
            errors++;
            $display("FAIL async_reset: got %s, expected %s", fmt(o), fmt(rst_exp));
        end
        m_mode = M_STOP;
        m_k    = 0;
        m_ovr  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 1);
            e = model_out();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL async_reset_after c%0d: got %s, expected %s", c, fmt(o), fmt(e));
            end
            tick();
        end
    endtask

`ifdef DPC_OVERRUN_EN
    task automatic test_overrun();
        obs_t o, e;
        goto_extin();
        for (int c = 0; c < SET_LEN + 4; c++) begin
            drive(c == SET_LEN + 1, c == SET_LEN, c == 0 || c == N_TAPS + 1);
            e = model_out();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL overrun c%0d: got %s, expected %s", c, fmt(o), fmt(e));
            end
            if (c == N_TAPS + 2 || c == SET_LEN + 2) begin
                checks++;
                if (o.ovr !== (c == N_TAPS + 2)) begin
                    errors++;
                    $display("FAIL overrun_flag c%0d: got %b, expected %b", c, o.ovr, c == N_TAPS + 2);
                end
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        obs_t o, e;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35);
            e = model_out();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random c%0d: got %s, expected %s", c, fmt(o), fmt(e));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_abort_mac();
        test_abort_extout();
        test_ext_abort_extin();
        test_async_reset();
`ifdef DPC_OVERRUN_EN
        test_overrun();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
